// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU sequencing controller.
// Opcodes, condition codes, FSM states and flag bit positions.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // TST/TEQ/CMP/CMN occupy 1000..1011
    function automatic logic is_compare(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition-code check against NZCV flags.
// Encoding 4'hF never passes.
module alu_cond_eval
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // decode the condition against the flag bits
    always_comb begin
        pass = 1'b0;
        unique case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = n == v;
            CC_LT: pass = n != v;
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            CC_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// Round-robin front end for the 32-bit ALU: arbitrates two
// requesters, gates on condition codes, owns the NZCV register.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [7:0]        req_op,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [1:0]        req_s,
    input  logic [7:0]        req_cond,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_nin,
    output logic              alu_zin,
    output logic              alu_cin,
    output logic              alu_vin,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_exec,
    output logic              rsp_wb,
    output logic [3:0]        flags
);

    state_t state;
    state_t state_nx;

    logic       last_grant;
    logic [1:0] grant;
    logic       accept;
    logic       sel_id;
    logic [3:0] sel_cond;
    logic       sel_pass;
    logic       lat_id;
    logic       lat_s;
    logic       lat_pass;
    logic       upd_flags;

    assign alu_nin = flags[FLAG_N];
    assign alu_zin = flags[FLAG_Z];
    assign alu_cin = flags[FLAG_C];
    assign alu_vin = flags[FLAG_V];

    // round-robin: on contention favour the one not granted last
    always_comb begin
        grant    = 2'b00;
        grant[0] = req_valid[0] && (!req_valid[1] || last_grant);
        grant[1] = req_valid[1] && (!req_valid[0] || !last_grant);
    end

    assign accept   = |(req_valid & req_ready);
    assign sel_id   = req_ready[1];
    assign sel_cond = sel_id ? req_cond[7:4] : req_cond[3:0];

    alu_cond_eval u_cond (
        .cond (sel_cond),
        .nzcv (flags),
        .pass (sel_pass)
    );

    assign upd_flags = lat_pass && (is_compare(alu_op) || lat_s);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state and request-side ready
    always_comb begin
        state_nx  = state;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (accept) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // latch the granted request into the ALU operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 4'h0;
            lat_id     <= 1'b0;
            lat_s      <= 1'b0;
            lat_pass   <= 1'b0;
            last_grant <= 1'b1;
        end else if (state == IDLE && accept) begin
            alu_a      <= sel_id ? req_a[2*DATA_W-1:DATA_W]
                                 : req_a[DATA_W-1:0];
            alu_b      <= sel_id ? req_b[2*DATA_W-1:DATA_W]
                                 : req_b[DATA_W-1:0];
            alu_op     <= sel_id ? req_op[7:4] : req_op[3:0];
            lat_s      <= req_s[sel_id];
            lat_pass   <= sel_pass;
            lat_id     <= sel_id;
            last_grant <= sel_id;
        end
    end

    // capture result and flags after EXEC, hold until handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
            rsp_exec  <= 1'b0;
            rsp_wb    <= 1'b0;
            flags     <= FLAGS_RST;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_y     <= lat_pass ? alu_y : '0;
            rsp_exec  <= lat_pass;
            rsp_wb    <= lat_pass && !is_compare(alu_op);
            if (upd_flags) begin
                flags <= {alu_n, alu_z, alu_c, alu_v};
            end
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl with a behavioural ALU model.
// Directed vectors push expectations; a monitor pops them.
module tb_alu_ctrl;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [7:0]    req_op;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic [1:0]    req_s;
    logic [7:0]    req_cond;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;
    logic          alu_nin;
    logic          alu_zin;
    logic          alu_cin;
    logic          alu_vin;
    logic [DW-1:0] alu_y;
    logic          alu_n;
    logic          alu_z;
    logic          alu_c;
    logic          alu_v;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_y;
    logic          rsp_exec;
    logic          rsp_wb;
    logic [3:0]    flags;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] y;
        logic          ex;
        logic          wb;
        logic [3:0]    fl;
    } exp_t;

    exp_t q[$];

    alu_ctrl #(.DATA_W(DW), .FLAGS_RST(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_s(req_s), .req_cond(req_cond),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_nin(alu_nin), .alu_zin(alu_zin),
        .alu_cin(alu_cin), .alu_vin(alu_vin),
        .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z),
        .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_exec(rsp_exec),
        .rsp_wb(rsp_wb), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW+1:0] addc(input logic [DW-1:0] x,
                                           input logic [DW-1:0] y,
                                           input logic ci);
        logic [DW:0] t;
        logic        ov;
        t  = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, ci};
        ov = (x[DW-1] == y[DW-1]) && (t[DW-1] != x[DW-1]);
        return {t[DW], ov, t[DW-1:0]};
    endfunction

    // behavioural ALU, ARM data-processing semantics
    always_comb begin
        logic [DW+1:0] r;
        logic          arith;
        r     = '0;
        arith = 1'b1;
        case (alu_op)
            4'h2, 4'hA: r = addc(alu_a, ~alu_b, 1'b1);
            4'h3:       r = addc(alu_b, ~alu_a, 1'b1);
            4'h4, 4'hB: r = addc(alu_a, alu_b, 1'b0);
            4'h5:       r = addc(alu_a, alu_b, alu_cin);
            4'h6:       r = addc(alu_a, ~alu_b, alu_cin);
            4'h7:       r = addc(alu_b, ~alu_a, alu_cin);
            default:    arith = 1'b0;
        endcase
        alu_y = r[DW-1:0];
        alu_c = r[DW+1];
        alu_v = r[DW];
        if (!arith) begin
            alu_c = alu_cin;
            alu_v = alu_vin;
            case (alu_op)
                4'h0, 4'h8: alu_y = alu_a & alu_b;
                4'h1, 4'h9: alu_y = alu_a ^ alu_b;
                4'hC:       alu_y = alu_a | alu_b;
                4'hD:       alu_y = alu_b;
                4'hE:       alu_y = alu_a & ~alu_b;
                default:    alu_y = ~alu_b;
            endcase
        end
        alu_n = alu_y[DW-1];
        alu_z = alu_y == '0;
    end

    // monitor: pop one expectation per response handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rsp_valid) begin
                checks++;
                if (req_ready !== 2'b00) begin
                    errors++;
                    $display("FAIL ready_in_resp got %b want 00",
                             req_ready);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp id=%0d y=%h",
                             rsp_id, rsp_y);
                end else begin
                    e = q.pop_front();
                    if ({rsp_id, rsp_y, rsp_exec, rsp_wb, flags} !==
                        {e.id, e.y, e.ex, e.wb, e.fl}) begin
                        errors++;
                        $display("FAIL rsp got id=%0d y=%h ex=%0d wb=%0d fl=%b want id=%0d y=%h ex=%0d wb=%0d fl=%b",
                                 rsp_id, rsp_y, rsp_exec, rsp_wb, flags,
                                 e.id, e.y, e.ex, e.wb, e.fl);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic drive(input int p, input logic [3:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic s, input logic [3:0] cond);
        req_op[4*p +: 4]    = op;
        req_a[DW*p +: DW]   = a;
        req_b[DW*p +: DW]   = b;
        req_s[p]            = s;
        req_cond[4*p +: 4]  = cond;
        req_valid[p]        = 1'b1;
    endtask

    task automatic expect_rsp(input int p, input logic [DW-1:0] y,
                              input logic ex, input logic wb,
                              input logic [3:0] fl);
        exp_t e;
        e.id = p[0];
        e.y  = y;
        e.ex = ex;
        e.wb = wb;
        e.fl = fl;
        q.push_back(e);
    endtask

    // wait at negedges until requester p sees ready
    task automatic wait_ready(input int p, input string nm);
        int n;
        n = 0;
        while (!req_ready[p] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[p]) begin
            checks++;
            errors++;
            $display("FAIL %s accept_timeout got 0 want 1", nm);
        end
    endtask

    task automatic send(input int p, input logic [3:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic s, input logic [3:0] cond,
                        input logic [DW-1:0] ey, input logic ex,
                        input logic wb, input logic [3:0] fl,
                        input string nm);
        expect_rsp(p, ey, ex, wb, fl);
        @(posedge clk);
        #1;
        drive(p, op, a, b, s, cond);
        @(negedge clk);
        wait_ready(p, nm);
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
        @(negedge clk);
        chk({nm, "_lat_exec"}, {31'b0, rsp_valid}, 0);
        @(negedge clk);
        chk({nm, "_lat_resp"}, {31'b0, rsp_valid}, 1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain"}, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_s     = '0;
        req_cond  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_flags", {28'b0, flags}, 0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_alu_op", {28'b0, alu_op}, 0);
        chk("rst_alu_a", alu_a, 0);
        rst_n = 1'b1;

        // basic ADD with set-flags
        send(0, 4'h4, 5, 7, 1'b1, 4'hE, 12, 1, 1, 4'b0000, "add");
        drain("add");

        // contention after reset: grants 0,1,0
        do_reset();
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            #1;
            drive(0, 4'h4, 1, 2, 1'b0, 4'hE);
            drive(1, 4'h2, 10, 4, 1'b0, 4'hE);
            @(negedge clk);
            while (req_ready == 2'b00 && rsp_valid !== 1'bx) begin
                @(negedge clk);
                if (!rst_n) break;
            end
            chk("rr_grant", {30'b0, req_ready},
                (r == 1) ? 2 : 1);
            if (r == 1) expect_rsp(1, 6, 1, 1, 4'b0000);
            else        expect_rsp(0, 3, 1, 1, 4'b0000);
            @(posedge clk);
            #1;
            req_valid = 2'b00;
        end
        drain("rr");

        // compare sets Z and C, then conditional ADDs
        send(1, 4'hA, 3, 3, 1'b0, 4'hE, 0, 1, 0, 4'b0110, "cmp");
        send(0, 4'h4, 1, 1, 1'b0, 4'h0, 2, 1, 1, 4'b0110, "add_eq");
        send(0, 4'h4, 1, 1, 1'b0, 4'h1, 0, 0, 0, 4'b0110, "add_ne");
        drain("cond");

        // back-pressure on the response side
        expect_rsp(0, 32'h55, 1, 1, 4'b0110);
        expect_rsp(1, 5, 1, 1, 4'b0010);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 4'hD, 0, 32'h55, 1'b0, 4'hE);
        @(negedge clk);
        wait_ready(0, "stall");
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        drive(1, 4'h2, 9, 4, 1'b1, 4'hE);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, rsp_valid}, 1);
            chk("stall_y", rsp_y, 32'h55);
            chk("stall_id", {31'b0, rsp_id}, 0);
            chk("stall_ready", {30'b0, req_ready}, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_ready", {30'b0, req_ready}, 2);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain("stall");

        // never condition leaves flags alone
        send(0, 4'h4, 1, 1, 1'b1, 4'hF, 0, 0, 0, 4'b0010, "cond_nv");
        drain("nv");

        // reset while the op is in EXEC
        @(posedge clk);
        #1;
        drive(0, 4'h4, 2, 2, 1'b1, 4'hE);
        @(negedge clk);
        wait_ready(0, "rst_exec");
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("rst_exec_flags", {28'b0, flags}, 0);
        chk("rst_exec_valid", {31'b0, rsp_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_exec_norsp", {31'b0, rsp_valid}, 0);
        drive(0, 4'h4, 1, 2, 1'b0, 4'hE);
        drive(1, 4'h2, 10, 4, 1'b0, 4'hE);
        #1;
        chk("rst_exec_grant", {30'b0, req_ready}, 1);
        expect_rsp(0, 3, 1, 1, 4'b0000);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain("rst_exec");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
